// File: rtl/screen_ram_arbiter_pkg.sv
// Shared screen RAM definitions: screen window geometry and the port-owner / read-tag encodings
// used by the work/screen RAM arbiter.
package screen_defs;

  localparam logic [10:0] SCREEN_BASE = 11'h200;
  localparam int          SCREEN_SIZE = 1024;

  // Who drives the single RAM port in the current cycle.
  typedef enum logic [1:0] {
    OWN_CPU   = 2'd0,
    OWN_VID   = 2'd1,
    OWN_DRAIN = 2'd2
  } owner_e;

  // Which consumer the RAM read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_VID    = 2'd1,
    TAG_CPU_RD = 2'd2
  } rd_tag_e;

endpackage

// File: rtl/screen_ram_arbiter_sync_fifo.sv
// First-word-fall-through synchronous FIFO holding posted CPU writes ({addr, data} entries).
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/empty guard every read of stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/screen_ram_arbiter.sv
// Shares the single work/screen RAM port between the VGA renderer (absolute priority),
// a posted-write drain FIFO, and direct CPU accesses; steers returning read data by tag.
module screen_ram_arbiter
  import screen_defs::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_en,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  output logic [DATA_WIDTH-1:0] cpu_dout,
  output logic                  cpu_rdy,
  input  logic                  vid_en,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  wbuf_overflow
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  owner_e          owner;
  rd_tag_e         tag_d;
  rd_tag_e         tag_q;
  logic            cpu_rd;
  logic            cpu_wr;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_head;
  logic            wr_drop;

  assign cpu_rd = cpu_en & ~cpu_we;
  assign cpu_wr = cpu_en & cpu_we;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({cpu_addr, cpu_din}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    if (vid_en)           owner = OWN_VID;
    else if (!fifo_empty) owner = OWN_DRAIN;
    else                  owner = OWN_CPU;
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cpu_addr;
    ram_din   = cpu_din;
    cpu_rdy   = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    tag_d     = TAG_NONE;
    if (!reset) begin
      unique case (owner)
        OWN_VID: begin
          ram_en    = 1'b1;
          ram_addr  = vid_addr;
          tag_d     = TAG_VID;
          fifo_push = cpu_wr;
          cpu_rdy   = cpu_wr;
        end
        OWN_DRAIN: begin
          ram_en              = 1'b1;
          ram_we              = 1'b1;
          {ram_addr, ram_din} = fifo_head;
          fifo_pop            = 1'b1;
          fifo_push           = cpu_wr;
          cpu_rdy             = cpu_wr;
        end
        default: begin
          ram_en  = cpu_en;
          ram_we  = cpu_wr;
          cpu_rdy = 1'b1;
          tag_d   = cpu_rd ? TAG_CPU_RD : TAG_NONE;
        end
      endcase
    end
  end

  // A posted write is lost only when the buffer is full and nothing leaves it this cycle.
  assign wr_drop = fifo_push & fifo_full & ~fifo_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q         <= TAG_NONE;
      cpu_dout      <= '0;
      vid_data      <= '0;
      wbuf_overflow <= 1'b0;
    end else begin
      tag_q <= tag_d;
      if (wr_drop) wbuf_overflow <= 1'b1;
      case (tag_q)
        TAG_VID:    vid_data <= ram_dout;
        TAG_CPU_RD: cpu_dout <= ram_dout;
        default:    ;
      endcase
    end
  end

endmodule
